// File: rtl/conv_2d_pipe.sv
// conv_2d_pipe: KxK sliding-window convolution with a runtime-loadable kernel.
// Window and kernel registers feed a product / adder-tree / round-saturate pipeline.
module conv_2d_pipe #(
    parameter int K        = 3,
    parameter int NB_DATA  = 8,
    parameter int NB_COEFF = 8,
    parameter int NB_OUT   = 8,
    parameter int SHIFT    = 6,
    localparam int NB_PROD = NB_DATA + NB_COEFF,
    localparam int NB_SUM  = NB_PROD + $clog2(K * K)
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_load_knl,
    input  logic                     i_flush,
    input  logic [K*NB_DATA-1:0]     i_data,
    output logic                     o_knl_ready,
    output logic                     o_valid,
    output logic signed [NB_SUM-1:0] o_sum,
    output logic signed [NB_OUT-1:0] o_pixel
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int FW = $clog2(K + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(K - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(K);
    localparam logic signed [NB_SUM:0] RND_HALF = (NB_SUM+1)'(2 ** SHIFT / 2);
    localparam logic signed [NB_SUM:0] SAT_MAX  = (NB_SUM+1)'(2 ** (NB_OUT - 1) - 1);
    localparam logic signed [NB_SUM:0] SAT_MIN  = (NB_SUM+1)'(-(2 ** (NB_OUT - 1)));

    logic signed [NB_COEFF-1:0] knl_reg [K][K];
    logic signed [NB_DATA-1:0]  win_reg [K][K];
    logic [CW-1:0]              col_cnt_reg;
    logic [FW-1:0]              fill_cnt_reg;
    logic [FW-1:0]              fill_cnt_next;
    logic                       knl_ready_reg;
    logic                       load_col;
    logic                       pix_acc;
    logic                       productive;
    logic                       win_valid_reg;
    logic                       prod_valid_reg;
    logic                       sum_valid_reg;
    logic signed [NB_PROD-1:0]  prod_next [K*K];
    logic signed [NB_PROD-1:0]  prod_reg  [K*K];
    logic signed [NB_SUM-1:0]   sum_next;
    logic signed [NB_SUM-1:0]   sum_reg;
    logic signed [NB_SUM:0]     rnd_sum;
    logic signed [NB_OUT-1:0]   pixel_next;

    assign load_col      = i_valid && i_load_knl;
    assign pix_acc       = i_valid && !i_load_knl && !i_flush;
    assign fill_cnt_next = (fill_cnt_reg == FILL_FULL) ? FILL_FULL : fill_cnt_reg + 1'b1;
    assign productive    = pix_acc && (fill_cnt_next == FILL_FULL) && knl_ready_reg;
    assign o_knl_ready   = knl_ready_reg;

    // Kernel side ignores flush: a load column is taken even in a flush cycle.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    knl_reg[r][c] <= '0;
            col_cnt_reg   <= '0;
            knl_ready_reg <= 1'b0;
        end else if (load_col) begin
            for (int r = 0; r < K; r++)
                knl_reg[r][col_cnt_reg] <= i_data[r*NB_DATA +: NB_COEFF];
            if (col_cnt_reg == COL_LAST) begin
                col_cnt_reg   <= '0;
                knl_ready_reg <= 1'b1;
            end else begin
                if (col_cnt_reg == '0)
                    knl_ready_reg <= 1'b0;
                col_cnt_reg <= col_cnt_reg + 1'b1;
            end
        end
    end

    // Column 0 holds the newest pixel column; older columns shift towards K-1.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst || i_flush) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win_reg[r][c] <= '0;
            fill_cnt_reg <= '0;
        end else if (pix_acc) begin
            for (int r = 0; r < K; r++) begin
                win_reg[r][0] <= i_data[r*NB_DATA +: NB_DATA];
                for (int c = 1; c < K; c++)
                    win_reg[r][c] <= win_reg[r][c-1];
            end
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < K*K; gi++) begin : g_prod
            assign prod_next[gi] = NB_PROD'(win_reg[gi / K][gi % K]) * NB_PROD'(knl_reg[gi / K][gi % K]);
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < K*K; i++)
            sum_next = sum_next + NB_SUM'(prod_reg[i]);
    end

    // One extra bit of headroom so the rounding offset can never wrap.
    always_comb begin
        rnd_sum = ((NB_SUM+1)'(sum_reg) + RND_HALF) >>> SHIFT;
        if (rnd_sum > SAT_MAX)
            pixel_next = NB_OUT'(SAT_MAX);
        else if (rnd_sum < SAT_MIN)
            pixel_next = NB_OUT'(SAT_MIN);
        else
            pixel_next = NB_OUT'(rnd_sum);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            win_valid_reg  <= 1'b0;
            prod_valid_reg <= 1'b0;
            sum_valid_reg  <= 1'b0;
            o_valid        <= 1'b0;
            for (int i = 0; i < K*K; i++)
                prod_reg[i] <= '0;
            sum_reg <= '0;
            o_sum   <= '0;
            o_pixel <= '0;
        end else begin
            win_valid_reg  <= productive;
            prod_valid_reg <= win_valid_reg && !i_flush;
            sum_valid_reg  <= prod_valid_reg && !i_flush;
            o_valid        <= sum_valid_reg && !i_flush;
            for (int i = 0; i < K*K; i++)
                prod_reg[i] <= prod_next[i];
            sum_reg <= sum_next;
            if (sum_valid_reg && !i_flush) begin
                o_sum   <= sum_reg;
                o_pixel <= pixel_next;
            end
        end
    end
endmodule
